uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO, a baud-rate divider and runtime-selectable parity and stop bits. It accepts words through a valid/ready handshake, buffers them, and serialises each one LSB-first on the tx line as start, data, optional parity, then 1 or 2 stop bits. It sits between the bus-side register block and the pad, replacing the one-bit-per-clock transmitter.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
CLKS_PER_BIT, 16, clock cycles per bit time (>=2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_data  in  DATA_WIDTH  word to transmit
in_valid  in  1  in_data is valid
in_ready  out  1  FIFO can accept; equals !full
parity_mode  in  2  00 none, 01 odd, 10 even, 11 treated as none
stop_two  in  1  0 = 1 stop bit, 1 = 2 stop bits
tx  out  1  serial line, idle high
busy  out  1  frame in progress (start bit through last stop bit)
tx_done  out  1  one-cycle pulse per completed frame
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: tx=1, busy=0, tx_done=0, in_ready=1, fifo_count=0. FIFO pointers are cleared and the FSM enters IDLE.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), buffered words are discarded, and no tx_done is issued.
- Push: a word is written on a rising edge where in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH).
  - A push while full cannot occur. A push and a pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, latch parity_mode and stop_two, compute the parity bit, then set tx<=0, busy<=1, clear the baud counter, go to START.
  - Baud counter counts 0..CLKS_PER_BIT-1. Every bit is held on tx for exactly CLKS_PER_BIT cycles. State advances when the counter equals CLKS_PER_BIT-1.
  - START -> DATA: drives shift_reg[0]. Each following bit time shifts right.
  - DATA -> after DATA_WIDTH bits, go to PARITY if the latched mode is 01 or 10, otherwise STOP.
  - PARITY: tx = ~^data for odd mode, ^data for even mode, so the total count of ones over data plus parity is odd or even respectively.
  - STOP: tx=1 for 1 or 2 bit times, per latched stop_two.
  - On STOP end: tx_done=1 for one cycle, busy<=0, go to IDLE.
- Latency: a word pushed at edge E into an empty FIFO with the FSM in IDLE gives tx=0 after edge E+1.
- Frame length = (1 + DATA_WIDTH + P + S) * CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames: the FSM spends exactly one clock in IDLE (tx=1, coinciding with the tx_done pulse) between frames.
- Config changes: changes to parity_mode or stop_two mid-frame take effect only at the next frame start.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input brk_req (1 bit) and state BREAK.
  - From IDLE with brk_req=1: go to BREAK. brk_req takes priority over a non-empty FIFO.
  - In BREAK: tx=0, busy=1, nothing is popped.
  - On brk_req=0: tx=1 for one full bit time (CLKS_PER_BIT cycles), then IDLE.
  - No tx_done is issued for a break.
  - brk_req asserted mid-frame is ignored until the frame ends.
- Undefined: no brk_req port and no BREAK state.

Test Plan:
1. DATA_WIDTH=8, CLKS_PER_BIT=4, parity 00, stop_two=0; push 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); start bit begins 1 cycle after push; a single tx_done pulse; busy high for exactly 40 cycles.
2. Parity 01 with 0x07, then parity 10 with 0x07 -> parity bit 0 (odd), then 1 (even); second frame has stop_two=1 and is 48 cycles long.
3. Push 5 words with FIFO_DEPTH=4 while idle -> in_ready drops after 4 pushes are buffered plus 1 popped; all 5 frames are sent in order with a 1-cycle tx=1 gap between them; 5 tx_done pulses; fifo_count ends at 0.
4. Assert rst mid-DATA with 2 words queued -> tx=1 immediately, fifo_count=0, no tx_done; after rst release the line stays idle.
5. Change parity_mode from 00 to 10 during the DATA state of a frame -> the current frame has no parity bit; the next frame carries even parity.
6. (UART_TX_BREAK_EN) Hold brk_req for 20 cycles while a word is queued -> tx=0 for 20 cycles, then tx=1 for 4 cycles, then the queued frame starts.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small TX FIFO, with runtime parity/stop selection.
// Latency: a word pushed into an empty FIFO while idle drives the start bit one clock later.
// Backpressure: in_ready = !full; words wait in the FIFO while a frame is on the line.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   in_data/in_valid/in_ready - word input handshake (push when in_valid && in_ready)
//   parity_mode   - 00 none, 01 odd, 10 even, 11 none (latched at frame start)
//   stop_two      - 0: one stop bit, 1: two stop bits (latched at frame start)
//   tx            - serial line, idle high
//   busy          - high from start bit through last stop bit
//   tx_done       - one-cycle pulse per completed frame
//   fifo_count    - occupied FIFO entries
//   brk_req       - only with UART_TX_BREAK_EN: hold the line low (break) from idle
//
// Optional feature macro: UART_TX_BREAK_EN adds brk_req and the BREAK state.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop_two,
`ifdef UART_TX_BREAK_EN
  input  logic                              brk_req,
`endif
  output logic                              tx,
  output logic                              busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign in_ready   = (count_q != FIFO_FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // Storage needs no reset: entries are only read once counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ----------------------------------------------------------------- FSM
  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [IW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [1:0]            mode_q, mode_d;
  logic                  two_q, two_d;
  logic                  stop2nd_q, stop2nd_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_end;
  logic                  brk_now;
`ifdef UART_TX_BREAK_EN
  logic                  rel_q, rel_d;   // break released, sending the recovery mark
  assign brk_now = brk_req;
`else
  assign brk_now = 1'b0;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    mode_d    = mode_q;
    two_d     = two_q;
    stop2nd_d = stop2nd_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_BREAK_EN
    rel_d     = rel_q;
`endif

    // Baud counter free-runs 0..CLKS_PER_BIT-1 outside IDLE; it wraps to 0
    // exactly when a bit boundary is taken, so every bit gets a full period.
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (brk_now) begin
`ifdef UART_TX_BREAK_EN
          state_d = S_BREAK;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          rel_d   = 1'b0;
`endif
        end else if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          mode_d  = parity_mode;
          two_d   = stop_two;
          par_d   = (parity_mode == 2'b01) ? ~^head : ^head;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            if (mode_q == 2'b01 || mode_q == 2'b10) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d      = 1'b1;
              stop2nd_d = 1'b0;
              state_d   = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          tx_d      = 1'b1;
          stop2nd_d = 1'b0;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          if (two_q && !stop2nd_q) begin
            stop2nd_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!rel_q) begin
          tx_d = 1'b0;
          if (!brk_now) begin
            rel_d  = 1'b1;
            tx_d   = 1'b1;
            baud_d = '0;
          end
        end else if (baud_end) begin
          busy_d  = 1'b0;
          rel_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Asynchronous reset drops tx back to idle-high at once and discards the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      mode_q    <= 2'b00;
      two_q     <= 1'b0;
      stop2nd_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      rel_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      mode_q    <= mode_d;
      two_q     <= two_d;
      stop2nd_q <= stop2nd_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_BREAK_EN
      rel_q     <= rel_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DATA_WIDTH=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frames are described as hand-built vectors, bit i = i-th bit on the line.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] parity_mode;
  logic       stop_two;
`ifdef UART_TX_BREAK_EN
  logic       brk_req;
`endif
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .parity_mode(parity_mode),
    .stop_two   (stop_two),
`ifdef UART_TX_BREAK_EN
    .brk_req    (brk_req),
`endif
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called with the current sample being bit-time sample 'skip' of a frame;
  // returns at the idle cycle that follows the frame.
  task automatic check_frame(input logic [11:0] bits, input int len, input int skip,
                             input string tag);
    for (int i = skip; i < len * CPB; i++) begin
      chk({tag, " tx"}, 32'(tx), 32'(bits[i / CPB]));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done"}, 32'(tx_done), 32'd0);
      tick();
    end
    chk({tag, " end done"}, 32'(tx_done), 32'd1);
    chk({tag, " end busy"}, 32'(busy), 32'd0);
    chk({tag, " end tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words [5];
    int lows;
    int dones;
    int w;

    rst         = 1'b1;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    parity_mode = 2'b00;
    stop_two    = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_req     = 1'b0;
`endif
    #12;
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(tx_done), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: 0xA5, no parity, one stop -> 0,1,0,1,0,0,1,0,1,1
    push(8'hA5);
    chk("t1 tx before start", 32'(tx), 32'd1);
    chk("t1 count", 32'(fifo_count), 32'd1);
    tick();
    check_frame({2'b00, 1'b1, 8'hA5, 1'b0}, 10, 0, "t1");

    // 2: 0x07 odd parity -> parity 0; then even + two stops -> parity 1, 48 cycles
    parity_mode = 2'b01;
    push(8'h07);
    tick();
    check_frame({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0, "t2 odd");
    parity_mode = 2'b10;
    stop_two    = 1'b1;
    push(8'h07);
    tick();
    check_frame({2'b11, 1'b1, 8'h07, 1'b0}, 12, 0, "t2 even");
    parity_mode = 2'b00;
    stop_two    = 1'b0;

    // 3: five back-to-back pushes into a depth-4 FIFO
    words[0] = 8'h01;
    words[1] = 8'h80;
    words[2] = 8'hFF;
    words[3] = 8'h00;
    words[4] = 8'h3C;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = words[k];
      if (k == 4) chk("t3 ready before 5th", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("t3 count full", 32'(fifo_count), 32'd4);
    chk("t3 ready full", 32'(in_ready), 32'd0);
    check_frame({2'b00, 1'b1, words[0], 1'b0}, 10, 3, "t3 w0");
    for (int k = 1; k < 5; k++) begin
      chk("t3 gap count", 32'(fifo_count), 32'(5 - k));
      tick();
      check_frame({2'b00, 1'b1, words[k], 1'b0}, 10, 0, "t3 wk");
    end
    chk("t3 final count", 32'(fifo_count), 32'd0);
    chk("t3 final ready", 32'(in_ready), 32'd1);
    tick();

    // 4: reset in the middle of DATA with two words queued
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_data  = 8'h11;
    tick();
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("t4 tx in data", 32'(tx), 32'd0);
    chk("t4 queued", 32'(fifo_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t4 async tx", 32'(tx), 32'd1);
    chk("t4 async count", 32'(fifo_count), 32'd0);
    chk("t4 async busy", 32'(busy), 32'd0);
    chk("t4 async done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("t4 idle line lows", 32'(lows), 32'd0);
    chk("t4 no done", 32'(dones), 32'd0);
    chk("t4 count after", 32'(fifo_count), 32'd0);

    // 5: parity change during DATA only affects the next frame
    push(8'h03);
    tick();
    repeat (6) tick();
    parity_mode = 2'b10;
    in_data     = 8'h01;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    check_frame({2'b00, 1'b1, 8'h03, 1'b0}, 10, 7, "t5 cur");
    chk("t5 queued", 32'(fifo_count), 32'd1);
    tick();
    check_frame({1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, "t5 next");
    parity_mode = 2'b00;

`ifdef UART_TX_BREAK_EN
    // 6: break requested together with a queued word wins; frame follows
    in_data  = 8'h55;
    in_valid = 1'b1;
    brk_req  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t6 break tx", 32'(tx), 32'd0);
      chk("t6 break busy", 32'(busy), 32'd1);
      if (i == 19) brk_req = 1'b0;
      tick();
    end
    for (int i = 0; i < CPB; i++) begin
      chk("t6 mark tx", 32'(tx), 32'd1);
      chk("t6 mark done", 32'(tx_done), 32'd0);
      tick();
    end
    w = 0;
    while (tx !== 1'b0 && w < 4) begin
      tick();
      w++;
    end
    chk("t6 frame start", 32'(tx), 32'd0);
    chk("t6 popped", 32'(fifo_count), 32'd0);
    repeat (60) tick();
`else
    w = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
